// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single synchronous BRAM port.
// Read data returns on a per-requester one-cycle strobe, one cycle after the accept.
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_write,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_data,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_data,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_write,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_data,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_data,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  logic                  grant0, grant1;
  logic                  prio_q, prio_d;
  logic                  rsp_pend_q, rsp_pend_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

  // Grants are masked during reset so nothing reaches the BRAM in that cycle.
  always_comb begin
    grant0 = ~i_rst & i_req0_valid & (~i_req1_valid | ~prio_q);
    grant1 = ~i_rst & i_req1_valid & (~i_req0_valid |  prio_q);
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  always_comb begin
    o_mem_write = 1'b0;
    o_mem_addr  = last_addr_q;
    o_mem_data  = '0;
    if (grant0) begin
      o_mem_write = i_req0_write;
      o_mem_addr  = i_req0_addr;
      o_mem_data  = i_req0_data;
    end else if (grant1) begin
      o_mem_write = i_req1_write;
      o_mem_addr  = i_req1_addr;
      o_mem_data  = i_req1_data;
    end
  end

  always_comb begin
    prio_d      = prio_q;
    rsp_pend_d  = 1'b0;
    rsp_id_d    = rsp_id_q;
    last_addr_d = last_addr_q;
    if (grant0) begin
      prio_d      = 1'b1;
      rsp_pend_d  = ~i_req0_write;
      last_addr_d = i_req0_addr;
      if (!i_req0_write) rsp_id_d = 1'b0;
    end else if (grant1) begin
      prio_d      = 1'b0;
      rsp_pend_d  = ~i_req1_write;
      last_addr_d = i_req1_addr;
      if (!i_req1_write) rsp_id_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio_q      <= 1'b0;
      rsp_pend_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      last_addr_q <= '0;
    end else begin
      prio_q      <= prio_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_id_q    <= rsp_id_d;
      last_addr_q <= last_addr_d;
    end
  end

  // A read accepted just before reset must not surface during the reset cycle.
  always_comb begin
    o_rsp0_valid = ~i_rst & rsp_pend_q & ~rsp_id_q;
    o_rsp1_valid = ~i_rst & rsp_pend_q &  rsp_id_q;
    o_rsp0_data  = o_rsp0_valid ? i_mem_data : '0;
    o_rsp1_data  = o_rsp1_valid ? i_mem_data : '0;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_bram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, w0, v1, w1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic          mw;
  logic [AW-1:0] ma;
  logic [DW-1:0] md, mrd;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_write(w0),
    .i_req0_addr(a0), .i_req0_data(d0),
    .o_rsp0_valid(rv0), .o_rsp0_data(rd0),
    .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_write(w1),
    .i_req1_addr(a1), .i_req1_data(d1),
    .o_rsp1_valid(rv1), .o_rsp1_data(rd1),
    .o_mem_write(mw), .o_mem_addr(ma), .o_mem_data(md),
    .i_mem_data(mrd)
  );

  // Read-first synchronous BRAM.
  always @(posedge clk) begin
    if (mw) mem[ma] <= md;
    mrd <= mem[ma];
  end

  typedef struct {
    logic          v0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0, r1, rv0;
    logic [DW-1:0] rd0;
    logic          rv1;
    logic [DW-1:0] rd1;
    logic          mw;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
  } vec_t;

  vec_t vecs [0:9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv0, input logic iw0, input logic [AW-1:0] ia0, input logic [DW-1:0] id0,
                       input logic iv1, input logic iw1, input logic [AW-1:0] ia1, input logic [DW-1:0] id1);
    v0 = iv0; w0 = iw0; a0 = ia0; d0 = id0;
    v1 = iv1; w1 = iw1; a1 = ia1; d1 = id1;
  endtask

  initial begin
    int n0, n1;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //          v0 w0 a0 d0     v1 w1 a1 d1     r0 r1 rv0 rd0    rv1 rd1    mw ma md
    vecs[0] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00};
    vecs[1] = '{1, 1, 0, 8'hAA, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'hAA};
    vecs[2] = '{1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00};
    vecs[3] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 8'hAA, 0, 8'h00, 0, 0, 8'h00};
    vecs[4] = '{0, 0, 0, 8'h00, 1, 1, 1, 8'hBB, 0, 1, 0, 8'h00, 0, 8'h00, 1, 1, 8'hBB};
    vecs[5] = '{0, 0, 0, 8'h00, 1, 1, 5, 8'h11, 0, 1, 0, 8'h00, 0, 8'h00, 1, 5, 8'h11};
    vecs[6] = '{0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00};
    vecs[7] = '{1, 0, 0, 8'h00, 1, 0, 1, 8'h00, 1, 0, 0, 8'h00, 1, 8'hBB, 0, 0, 8'h00};
    vecs[8] = '{0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 0, 1, 1, 8'hAA, 0, 8'h00, 0, 1, 8'h00};
    vecs[9] = '{0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'hBB, 0, 1, 8'h00};

    next_cycle();
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      #3;
      chk($sformatf("v%0d_ready0", i), rdy0, vecs[i].r0);
      chk($sformatf("v%0d_ready1", i), rdy1, vecs[i].r1);
      chk($sformatf("v%0d_rsp0_valid", i), rv0, vecs[i].rv0);
      chk($sformatf("v%0d_rsp0_data", i), rd0, vecs[i].rd0);
      chk($sformatf("v%0d_rsp1_valid", i), rv1, vecs[i].rv1);
      chk($sformatf("v%0d_rsp1_data", i), rd1, vecs[i].rd1);
      chk($sformatf("v%0d_mem_write", i), mw, vecs[i].mw);
      chk($sformatf("v%0d_mem_addr", i), ma, vecs[i].ma);
      chk($sformatf("v%0d_mem_data", i), md, vecs[i].md);
      next_cycle();
    end

    // Continuous dual write demand: grants alternate starting with req0.
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1, 1, AW'(2*n0), DW'(n0), 1, 1, AW'(2*n1+1), DW'(n1+1));
      #3;
      chk($sformatf("alt%0d_ready0", k), rdy0, (k % 2) == 0);
      chk($sformatf("alt%0d_ready1", k), rdy1, (k % 2) == 1);
      if ((k % 2) == 0) n0++; else n1++;
      next_cycle();
    end

    // Read back addresses 0..7 through req0; expect 0,1,1,2,2,3,3,4.
    for (int j = 0; j < 9; j++) begin
      if (j < 8) drive(1, 0, AW'(j), 0, 0, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      if (j < 8) chk($sformatf("rb%0d_ready0", j), rdy0, 1'b1);
      if (j > 0) begin
        exp_d = ((j-1) % 2 == 0) ? DW'((j-1)/2) : DW'((j-1)/2 + 1);
        chk($sformatf("rb%0d_rsp0_valid", j-1), rv0, 1'b1);
        chk($sformatf("rb%0d_rsp0_data", j-1), rd0, exp_d);
      end
      chk($sformatf("rb%0d_rsp1_valid", j), rv1, 1'b0);
      next_cycle();
    end

    // Read accepted, then reset in the following cycle.
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    #3;
    chk("pre_rst_ready0", rdy0, 1'b1);
    next_cycle();
    rst = 1'b1;
    drive(1, 0, 0, 0, 1, 0, 1, 0);
    #3;
    chk("rst_ready0", rdy0, 1'b0);
    chk("rst_ready1", rdy1, 1'b0);
    chk("rst_rsp0_valid", rv0, 1'b0);
    chk("rst_rsp1_valid", rv1, 1'b0);
    chk("rst_mem_write", mw, 1'b0);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("post_rst_mem_addr", ma, 0);
    chk("post_rst_rsp0_valid", rv0, 1'b0);
    chk("post_rst_rsp1_valid", rv1, 1'b0);
    next_cycle();
    drive(1, 0, 0, 0, 1, 0, 1, 0);
    #3;
    chk("post_rst_conflict_ready0", rdy0, 1'b1);
    chk("post_rst_conflict_ready1", rdy1, 1'b0);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    #3;
    chk("post_rst_second_ready1", rdy1, 1'b1);
    chk("post_rst_rsp0_valid2", rv0, 1'b1);
    chk("post_rst_rsp0_data", rd0, 8'h00);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("post_rst_rsp1_valid", rv1, 1'b1);
    chk("post_rst_rsp1_data", rd1, 8'h01);
    chk("post_rst_rsp0_quiet", rv0, 1'b0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
